// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter for the single-wire link.
// Accepts one WIDTH-bit word per valid/ready handshake and shifts it out
// MSB-first, one bit per clock, with frame_start / frame_last markers.
//
// Handshake: a word is taken on any rising edge where din_valid and din_ready
// are both 1. din_ready is high in IDLE and during the frame_last cycle (so
// frames can run gapless), and low otherwise and whenever rstn is low.
//
// Build option: define PISO_PARITY_EN to append one even-parity bit (XOR of
// the accepted word) after the LSB; frame_last then marks the parity bit.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
    // The LSB is not the final bit: the parity bit follows it.
    localparam bit LAST_ON_LSB = 1'b0;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
    localparam bit LAST_ON_LSB = 1'b1;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             sout_q;
    logic             sout_valid_q;
    logic             frame_start_q;
    logic             frame_last_q;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif
    logic             accept;

    // Ready when idle, or while the final bit of the current frame is on the line.
    assign din_ready = rstn && ((state_q == ST_IDLE) || frame_last_q);
    assign accept    = din_valid && din_ready;

    // shreg_q holds the bits still to be sent, next one at the MSB.
    assign shreg_d = shreg_q << 1;
    assign cnt_d   = cnt_q - CW'(1);

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;

    // Frame FSM with registered line outputs; reset wins over everything,
    // and an accept restarts the frame from the new word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else if (accept) begin
            // MSB goes straight to the output register; the rest waits in shreg_q.
            state_q       <= ST_SHIFT;
            shreg_q       <= din << 1;
            cnt_q         <= CW'(WIDTH - 1);
            sout_q        <= din[WIDTH-1];
            sout_valid_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_last_q  <= LAST_ON_LSB && (WIDTH == 1);
`ifdef PISO_PARITY_EN
            parity_q      <= ^din;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        state_q       <= ST_SHIFT;
                        shreg_q       <= shreg_d;
                        cnt_q         <= cnt_d;
                        sout_q        <= shreg_q[WIDTH-1];
                        sout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b0;
                        // cnt_q==1 means the bit being loaded now is the LSB.
                        frame_last_q  <= LAST_ON_LSB && (cnt_q == CW'(1));
                    end else begin
`ifdef PISO_PARITY_EN
                        state_q       <= ST_PARITY;
                        shreg_q       <= '0;
                        cnt_q         <= '0;
                        sout_q        <= parity_q;
                        sout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b0;
                        frame_last_q  <= 1'b1;
`else
                        state_q       <= ST_IDLE;
                        shreg_q       <= '0;
                        cnt_q         <= '0;
                        sout_q        <= 1'b0;
                        sout_valid_q  <= 1'b0;
                        frame_start_q <= 1'b0;
                        frame_last_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE, or the parity cycle ending without a new word.
                    state_q       <= ST_IDLE;
                    shreg_q       <= '0;
                    cnt_q         <= '0;
                    sout_q        <= 1'b0;
                    sout_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer (WIDTH=8 and WIDTH=1).
// Drivers push the expected {frame_start, frame_last, sout} triples into a
// queue when a word is accepted; negedge monitors pop and compare on every
// sout_valid cycle and require an all-zero line otherwise.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F  = W + PAR;
    localparam int F1 = 1 + PAR;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         frame_start;
    logic         frame_last;

    logic [0:0]   din1;
    logic         valid1;
    logic         ready1;
    logic         sout1;
    logic         sout1_valid;
    logic         start1;
    logic         last1;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    bit           mon_en   = 1'b0;
    logic [2:0]   exp_q[$];
    logic [2:0]   exp1_q[$];
    int           acc1_cyc[$];

    piso_serializer #(.WIDTH(W)) u_dut8 (
        .clk         (clk),
        .rstn        (rstn),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    piso_serializer #(.WIDTH(1)) u_dut1 (
        .clk         (clk),
        .rstn        (rstn),
        .din         (din1),
        .din_valid   (valid1),
        .din_ready   (ready1),
        .sout        (sout1),
        .sout_valid  (sout1_valid),
        .frame_start (start1),
        .frame_last  (last1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected triples {frame_start, frame_last, sout} for one WIDTH=8 frame
    task automatic push_frame8(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--)
            exp_q.push_back({(i == W - 1), (i == 0) && (PAR == 0), d[i]});
        if (PAR == 1)
            exp_q.push_back({1'b0, 1'b1, ^d});
    endtask

    // Per-cycle din_ready check; ready expected at cycle r1 and from r2 on.
    // din_valid drops right after edge 'drop'.
    task automatic watch(input int c0, input int c1, input int r1, input int r2, input int drop);
        for (int c = c0; c <= c1; c++) begin
            @(negedge clk);
            check("ready8", din_ready, (c == r1) || (c >= r2));
            @(posedge clk);
            #1;
            if (c == drop) din_valid = 1'b0;
        end
    endtask

    // One isolated frame; called at posedge+1 with the DUT idle
    task automatic single8(input logic [W-1:0] d);
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        push_frame8(d);
        watch(1, F + 1, F, F, -1);
    endtask

    // WIDTH=1 driver: holds valid, waits (bounded) for ready, records accept cycle
    task automatic send1(input logic b);
        int n;
        din1   = b;
        valid1 = 1'b1;
        n      = 0;
        while (ready1 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL timeout1 actual=ready_low expected=ready_high");
        end else begin
            @(posedge clk);
            #1;
            acc1_cyc.push_back(cyc);
            if (PAR == 1) begin
                exp1_q.push_back({1'b1, 1'b0, b});
                exp1_q.push_back({1'b0, 1'b1, b});
            end else begin
                exp1_q.push_back({1'b1, 1'b1, b});
            end
        end
    endtask

    // Scoreboard monitor, WIDTH=8
    always @(negedge clk) begin
        if (mon_en) begin
            if (sout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bit8 actual=unexpected_bit expected=no_bit (t=%0t)", $time);
                end else begin
                    check("bit8", {29'd0, frame_start, frame_last, sout}, {29'd0, exp_q.pop_front()});
                end
            end else begin
                check("idle8", {29'd0, sout_valid, frame_start, frame_last, sout}, 32'd0);
            end
        end
    end

    // Scoreboard monitor, WIDTH=1
    always @(negedge clk) begin
        if (mon_en) begin
            if (sout1_valid === 1'b1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bit1 actual=unexpected_bit expected=no_bit (t=%0t)", $time);
                end else begin
                    check("bit1", {29'd0, start1, last1, sout1}, {29'd0, exp1_q.pop_front()});
                end
            end else begin
                check("idle1", {29'd0, sout1_valid, start1, last1, sout1}, 32'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        rstn      = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        din1      = '0;
        valid1    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs8", {28'd0, sout_valid, frame_start, frame_last, sout}, 32'd0);
        check("rst_outs1", {28'd0, sout1_valid, start1, last1, sout1}, 32'd0);
        check("rst_ready8", din_ready, 1'b0);
        check("rst_ready1", ready1, 1'b0);
        rstn = 1'b1;
        #1;
        check("post_rst_ready8", din_ready, 1'b1);
        check("post_rst_ready1", ready1, 1'b1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single frame A5
        single8(8'hA5);

        // Back-to-back FF then 00 with din_valid held high
        din       = 8'hFF;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din = 8'h00;
        push_frame8(8'hFF);
        push_frame8(8'h00);
        watch(1, 2 * F + 1, F, 2 * F, F);

        // Busy offer of 3C during an A5 frame: taken only at the frame_last edge
        din       = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        push_frame8(8'hA5);
        watch(1, 1, F, 2 * F, -1);
        din       = 8'h3C;
        din_valid = 1'b1;
        push_frame8(8'h3C);
        watch(2, 2 * F + 1, F, 2 * F, F);

        // Reset mid-frame at the cycle-4 edge, with a handshake offered during reset
        din       = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        for (int i = W - 1; i >= W - 4; i--)
            exp_q.push_back({(i == W - 1), 1'b0, din[i]});
        watch(1, 3, 99, 99, -1);
        @(negedge clk);
        check("ready8_c4", din_ready, 1'b0);
        rstn      = 1'b0;
        din       = 8'hFF;
        din_valid = 1'b1;
        #1;
        check("ready8_in_rst", din_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_rst_outs8", {28'd0, sout_valid, frame_start, frame_last, sout}, 32'd0);
        rstn      = 1'b1;
        din_valid = 1'b0;
        #1;
        check("after_rst_ready8", din_ready, 1'b1);
        @(posedge clk);
        #1;
        single8(8'h81);

        // Odd-weight word (parity 1 when the parity option is built in)
        single8(8'h07);

        // WIDTH=1: single bit, then gapless alternating words
        send1(1'b1);
        send1(1'b0);
        send1(1'b1);
        send1(1'b0);
        valid1 = 1'b0;
        if (acc1_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++)
                check("gap1", acc1_cyc[k] - acc1_cyc[k-1], F1);
        end else begin
            check("accepts1", acc1_cyc.size(), 4);
        end

        // Drain and report
        repeat (F + 4) @(posedge clk);
        @(negedge clk);
        check("drain8", exp_q.size(), 0);
        check("drain1", exp1_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
